pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 115 +++++++++++
 tb/tb_pc_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with redirect handling and a circular return-address stack.
// Call > ret > taken branch > stall > sequential; every redirect flushes for one cycle.
module pc_sequencer #(
  parameter logic [18:0] RESET_PC  = 19'h00000,
  parameter int          RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [18:0] branch_target_i,
  input  logic        is_call_i,
  input  logic        is_ret_i,
  input  logic [18:0] instr_pc_i,
  output logic [18:0] pc_o,
  output logic        pc_valid_o,
  output logic        flush_o,
  output logic        ras_empty_o,
  output logic        ras_full_o,
  output logic        ras_err_o
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [18:0]   pc_q, pc_d;
  logic          valid_q, valid_d;
  logic          flush_q, flush_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] top_q, top_d;
  logic [PW-1:0] top_m1;
  logic [18:0]   ret_addr;
  logic          push;
  logic          sel_call, sel_ret, sel_br, sel_stall;
  logic [18:0]   stack_q [RAS_DEPTH];

  assign ret_addr  = instr_pc_i + 19'd1;
  assign top_m1    = top_q - PW'(1);
  assign sel_call  = is_call_i;
  assign sel_ret   = is_ret_i & ~is_call_i;
  assign sel_br    = branch_taken_i & ~is_call_i & ~is_ret_i;
  assign sel_stall = stall_i & ~is_call_i & ~is_ret_i
                   & ~branch_taken_i;

  always_comb begin
    pc_d    = pc_q;
    flush_d = 1'b0;
    cnt_d   = cnt_q;
    top_d   = top_q;
    err_d   = err_q;
    push    = 1'b0;
    unique case (1'b1)
      sel_call: begin
        pc_d    = branch_target_i;
        flush_d = 1'b1;
        push    = 1'b1;
        top_d   = top_q + PW'(1);
        // full push overwrites the oldest slot
        if (cnt_q == FULL) err_d = 1'b1;
        else               cnt_d = cnt_q + CW'(1);
        if (is_ret_i) err_d = 1'b1;
      end
      sel_ret: begin
        flush_d = 1'b1;
        if (cnt_q == '0) begin
          pc_d  = ret_addr;
          err_d = 1'b1;
        end else begin
          pc_d  = stack_q[top_m1];
          top_d = top_m1;
          cnt_d = cnt_q - CW'(1);
        end
      end
      sel_br: begin
        pc_d    = branch_target_i;
        flush_d = 1'b1;
      end
      sel_stall: pc_d = pc_q;
      default:   pc_d = pc_q + 19'd1;
    endcase
    valid_d = ~flush_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      top_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      top_q   <= top_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stack_q[top_q] <= ret_addr;
  end

  assign pc_o        = pc_q;
  assign pc_valid_o  = valid_q;
  assign flush_o     = flush_q;
  assign ras_err_o   = err_q;
  assign ras_empty_o = (cnt_q == '0);
  assign ras_full_o  = (cnt_q == FULL);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: constant vector table, stack corner sequences,
// and random traffic against a queue-based reference model.
module tb_pc_sequencer;

  localparam logic [18:0] RPC = 19'h00000;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_i, branch_taken_i, is_call_i, is_ret_i;
  logic [18:0] branch_target_i, instr_pc_i;
  logic [18:0] pc_o;
  logic        pc_valid_o, flush_o, ras_empty_o, ras_full_o, ras_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [18:0] m_pc;
  logic        m_flush, m_valid, m_err;
  logic [18:0] m_stk[$];

  typedef struct {
    logic        st, br, call, ret;
    logic [18:0] tgt, ipc, pc;
    logic        fl, em, fu, er;
  } vec_t;

  vec_t tbl[14];

  pc_sequencer #(.RESET_PC(RPC), .RAS_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n),
    .stall_i(stall_i), .branch_taken_i(branch_taken_i),
    .branch_target_i(branch_target_i),
    .is_call_i(is_call_i), .is_ret_i(is_ret_i),
    .instr_pc_i(instr_pc_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .flush_o(flush_o),
    .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o),
    .ras_err_o(ras_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_cmp(input string tag);
    chk({tag, " pc"}, 32'(pc_o), 32'(m_pc));
    chk({tag, " flush"}, 32'(flush_o), 32'(m_flush));
    chk({tag, " valid"}, 32'(pc_valid_o), 32'(m_valid));
    chk({tag, " empty"}, 32'(ras_empty_o), 32'(m_stk.size() == 0));
    chk({tag, " full"}, 32'(ras_full_o), 32'(m_stk.size() == D));
    chk({tag, " err"}, 32'(ras_err_o), 32'(m_err));
  endtask

  task automatic model_step(input logic st, br, call, ret,
                            input logic [18:0] tgt, ipc);
    logic [18:0] nxt;
    nxt = ipc + 19'd1;
    if (call) begin
      if (m_stk.size() == D) begin
        void'(m_stk.pop_front());
        m_err = 1'b1;
      end
      m_stk.push_back(nxt);
      m_pc = tgt;
      if (ret) m_err = 1'b1;
    end else if (ret) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin
        m_pc  = nxt;
        m_err = 1'b1;
      end
    end else if (br) m_pc = tgt;
    else if (!st) m_pc = m_pc + 19'd1;
    m_flush = call | ret | br;
    m_valid = ~m_flush;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input logic st, br, call, ret,
                       input logic [18:0] tgt, ipc);
    stall_i = st; branch_taken_i = br;
    is_call_i = call; is_ret_i = ret;
    branch_target_i = tgt; instr_pc_i = ipc;
    @(posedge clk);
    model_step(st, br, call, ret, tgt, ipc);
    @(negedge clk);
    model_cmp("model");
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst pc", 32'(pc_o), 32'(RPC));
    chk("rst valid", 32'(pc_valid_o), 32'd0);
    chk("rst flush", 32'(flush_o), 32'd0);
    chk("rst empty", 32'(ras_empty_o), 32'd1);
    chk("rst full", 32'(ras_full_o), 32'd0);
    chk("rst err", 32'(ras_err_o), 32'd0);
    m_pc = RPC; m_flush = 1'b0; m_valid = 1'b0; m_err = 1'b0;
    m_stk.delete();
    stall_i = 0; branch_taken_i = 0; is_call_i = 0; is_ret_i = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    stall_i = 0; branch_taken_i = 0; is_call_i = 0; is_ret_i = 0;
    branch_target_i = '0; instr_pc_i = '0;

    //          st br ca re tgt        ipc        pc         fl em fu er
    tbl[0]  = '{0, 0, 0, 0, 19'h0,     19'h0,     19'h1,     0, 1, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 19'h0,     19'h0,     19'h2,     0, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 19'h0,     19'h0,     19'h3,     0, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 19'h0,     19'h0,     19'h4,     0, 1, 0, 0};
    tbl[4]  = '{1, 1, 0, 0, 19'h100,   19'h0,     19'h100,   1, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 19'h0,     19'h0,     19'h101,   0, 1, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 19'h0,     19'h0,     19'h101,   0, 1, 0, 0};
    tbl[7]  = '{0, 0, 1, 0, 19'h200,   19'h10,    19'h200,   1, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 19'h0,     19'h205,   19'h11,    1, 1, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 19'h0,     19'h0,     19'h12,    0, 1, 0, 0};
    tbl[10] = '{0, 1, 0, 0, 19'h7FFFE, 19'h0,     19'h7FFFE, 1, 1, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 19'h0,     19'h0,     19'h7FFFF, 0, 1, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 19'h0,     19'h0,     19'h00000, 0, 1, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 19'h0,     19'h0,     19'h00000, 0, 1, 0, 0};

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].st, tbl[i].br, tbl[i].call, tbl[i].ret,
            tbl[i].tgt, tbl[i].ipc);
      chk($sformatf("tbl%0d pc", i), 32'(pc_o), 32'(tbl[i].pc));
      chk($sformatf("tbl%0d flush", i), 32'(flush_o), 32'(tbl[i].fl));
      chk($sformatf("tbl%0d valid", i), 32'(pc_valid_o), 32'(!tbl[i].fl));
      chk($sformatf("tbl%0d empty", i), 32'(ras_empty_o), 32'(tbl[i].em));
      chk($sformatf("tbl%0d full", i), 32'(ras_full_o), 32'(tbl[i].fu));
      chk($sformatf("tbl%0d err", i), 32'(ras_err_o), 32'(tbl[i].er));
    end

    // Overflow: 9 calls then 9 rets
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(0, 0, 1, 0, 19'h2000 + 19'(i), 19'h1000 + 19'(16 * i));
      chk($sformatf("ovf call%0d full", i), 32'(ras_full_o), 32'(i >= 7));
      chk($sformatf("ovf call%0d err", i), 32'(ras_err_o), 32'(i == 8));
    end
    for (int j = 0; j < 9; j++) begin
      cycle(0, 0, 0, 1, 19'h0, 19'h3000 + 19'(j));
      if (j < 8)
        chk($sformatf("ovf ret%0d pc", j), 32'(pc_o),
            32'h1000 + 32'(16 * (8 - j)) + 32'd1);
      else
        chk("ovf ret8 pc", 32'(pc_o), 32'h3009);
      chk($sformatf("ovf ret%0d empty", j), 32'(ras_empty_o), 32'(j >= 7));
    end

    // Simultaneous call and ret, then reset clears error
    do_reset();
    cycle(0, 1, 1, 1, 19'h4444, 19'h0050);
    chk("callret pc", 32'(pc_o), 32'h4444);
    chk("callret empty", 32'(ras_empty_o), 32'd0);
    chk("callret err", 32'(ras_err_o), 32'd1);
    cycle(0, 0, 0, 1, 19'h0, 19'h0);
    chk("callret pop", 32'(pc_o), 32'h51);

    // Reset in the middle of a flush leaves no pending flush
    cycle(0, 1, 0, 0, 19'h0700, 19'h0);
    chk("midflush flush", 32'(flush_o), 32'd1);
    do_reset();
    cycle(0, 0, 0, 0, 19'h0, 19'h0);
    chk("postrst pc", 32'(pc_o), 32'(RPC + 19'd1));
    chk("postrst flush", 32'(flush_o), 32'd0);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      int r;
      logic c, rt;
      if ($urandom_range(0, 299) == 0) do_reset();
      r  = int'($urandom_range(0, 99));
      c  = (r < 14);
      rt = (r >= 11 && r < 28);
      cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0),
            c, rt, 19'($urandom), 19'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
